// File: rtl/saes32_round_seq.sv
// Sequencer issuing four chained saes32 ops (bs=0..3) to build one AES round output column.
// (Inv)ShiftRows is applied by choosing which state column feeds rs2 at each step.
module saes32_round_seq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_dec,
    input  logic        req_mix,
    input  logic [1:0]  req_col,
    input  logic [31:0] req_c0,
    input  logic [31:0] req_c1,
    input  logic [31:0] req_c2,
    input  logic [31:0] req_c3,
    input  logic [31:0] req_rk,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        fu_valid,
    output logic        fu_op_encs,
    output logic        fu_op_encsm,
    output logic        fu_op_decs,
    output logic        fu_op_decsm,
    output logic [31:0] fu_rs1,
    output logic [31:0] fu_rs2,
    output logic [1:0]  fu_bs,
    input  logic [31:0] fu_rd,
    input  logic        fu_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] acc_q, acc_d;
    logic        dec_q, dec_d;
    logic        mix_q, mix_d;
    logic [1:0]  col_q, col_d;
    logic [31:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [1:0]  src_idx;
    logic [31:0] src_col;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            dec_q   <= 1'b0;
            mix_q   <= 1'b0;
            col_q   <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            dec_q   <= dec_d;
            mix_q   <= mix_d;
            col_q   <= col_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        dec_d   = dec_q;
        mix_d   = mix_q;
        col_d   = col_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dec_d   = req_dec;
                    mix_d   = req_mix;
                    col_d   = req_col;
                    c0_d    = req_c0;
                    c1_d    = req_c1;
                    c2_d    = req_c2;
                    c3_d    = req_c3;
                    acc_d   = req_rk;
                    step_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (fu_ready) begin
                    acc_d = fu_rd;
                    if (step_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row r of the output column comes from column col+r (enc) or col-r (dec), mod 4.
    always_comb begin
        src_idx = dec_q ? (col_q - step_q) : (col_q + step_q);
        case (src_idx)
            2'd0:    src_col = c0_q;
            2'd1:    src_col = c1_q;
            2'd2:    src_col = c2_q;
            default: src_col = c3_q;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        fu_valid    = 1'b0;
        fu_op_encs  = 1'b0;
        fu_op_encsm = 1'b0;
        fu_op_decs  = 1'b0;
        fu_op_decsm = 1'b0;
        fu_rs1      = '0;
        fu_rs2      = '0;
        fu_bs       = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            ISSUE: begin
                fu_valid    = 1'b1;
                fu_rs1      = acc_q;
                fu_rs2      = src_col;
                fu_bs       = step_q;
                fu_op_encs  = !dec_q && !mix_q;
                fu_op_encsm = !dec_q &&  mix_q;
                fu_op_decs  =  dec_q && !mix_q;
                fu_op_decsm =  dec_q &&  mix_q;
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = acc_q;
            end
            default: ;
        endcase
    end

endmodule
